// File: rtl/ccm_arbiter.sv
// Three-way arbiter for the single-ported code memory: fetch (rd), loader (wr), debug (rd).
// Debug requester is compiled in only when CCM_DBG_PORT_EN is defined.
module ccm_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic [DATA_WIDTH-1:0] f_rd_data,
  output logic                  f_rd_valid,
  input  logic                  l_req,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wr_data,
  output logic                  l_gnt,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic [DATA_WIDTH-1:0] d_rd_data,
  output logic                  d_rd_valid,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_F = 2'd1, GNT_L = 2'd2, GNT_D = 2'd3} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       f_elig, l_elig, d_elig, f_force;
  logic       rd_tag_f, rd_tag_d;

  assign f_gnt = (state == GNT_F);
  assign l_gnt = (state == GNT_L);
  assign owner = state;

  assign f_rd_data  = mem_rd_data;
  assign d_rd_data  = mem_rd_data;
  assign f_rd_valid = rd_tag_f;

`ifdef CCM_DBG_PORT_EN
  assign d_gnt      = (state == GNT_D);
  assign d_rd_valid = rd_tag_d;
  assign d_elig     = d_req & ~d_gnt;
`else
  logic unused_dbg;
  assign d_gnt      = 1'b0;
  assign d_rd_valid = 1'b0;
  assign d_elig     = 1'b0;
  assign unused_dbg = d_req ^ rd_tag_d;
`endif

  // A requester whose grant is showing this cycle is ignored, so a held req
  // cannot be granted twice back to back.
  assign f_elig  = f_req & ~f_gnt;
  assign l_elig  = l_req & ~l_gnt;
  assign f_force = f_elig && (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    if (f_force)     state_nxt = GNT_F;
    else if (l_elig) state_nxt = GNT_L;
    else if (d_elig) state_nxt = GNT_D;
    else if (f_elig) state_nxt = GNT_F;

    if (!f_req || state_nxt == GNT_F)     starve_nxt = 4'd0;
    else if (f_elig && starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
  end

  // Memory command is registered alongside the owner state; the tag follows
  // the read grant by one cycle to line up with the macro's read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      rd_tag_f    <= 1'b0;
      rd_tag_d    <= 1'b0;
    end else begin
      mem_rd   <= (state_nxt == GNT_F) || (state_nxt == GNT_D);
      mem_wr   <= (state_nxt == GNT_L);
      rd_tag_f <= (state == GNT_F);
      rd_tag_d <= (state == GNT_D);
      if (state_nxt == GNT_F)      mem_rd_addr <= f_addr;
      else if (state_nxt == GNT_D) mem_rd_addr <= d_addr;
      if (state_nxt == GNT_L) begin
        mem_wr_addr <= l_addr;
        mem_wr_data <= l_wr_data;
      end
    end
  end

endmodule
